tlc_sequencer: RTL

TLC_SEQUENCER -- requirements
Module: tlc_sequencer

---
 rtl/tlc_sequencer_if.sv | 25 ++
 rtl/tlc_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tlc_sequencer_if.sv
// Signal bundle between the traffic-light sequencer and its environment.
// Latency: none, wires only.
// Backpressure: none; inputs are level/pulse samples, outputs are state decodes.
//
// master : drives TICK / SIDE_CAR / PED_BTN, observes lamps and STATE
// slave  : the sequencer itself
interface tlc_sequencer_if;
    logic       TICK;        // one-MCLK timing pulse from the clock divider
    logic       SIDE_CAR;    // side-street vehicle sensor
    logic       PED_BTN;     // pedestrian push button
    logic [2:0] MAIN_LIGHT;  // {R,Y,G} main street, one-hot
    logic [2:0] SIDE_LIGHT;  // {R,Y,G} side street, one-hot
    logic       WALK;        // pedestrian walk lamp
    logic [2:0] STATE;       // current state code

    modport master (
        output TICK, SIDE_CAR, PED_BTN,
        input  MAIN_LIGHT, SIDE_LIGHT, WALK, STATE
    );

    modport slave (
        input  TICK, SIDE_CAR, PED_BTN,
        output MAIN_LIGHT, SIDE_LIGHT, WALK, STATE
    );
endinterface

// File: rtl/tlc_sequencer.sv
// Main/side-street traffic-light sequencer with optional pedestrian walk phase.
// Latency: state advances on the MCLK edge carrying the final TICK; lamps decode the state register.
// Backpressure: none; requests are latched and served at the next decision point.
//
// Ports: MCLK clock; RESET_IN synchronous active-high reset (forces AR2);
//        bus (tlc_sequencer_if.slave): TICK, SIDE_CAR, PED_BTN in; MAIN_LIGHT, SIDE_LIGHT, WALK, STATE out.
// Build option: define TLC_PED_WALK_EN to compile in the pedestrian WALK phase.
module tlc_sequencer #(
    parameter int T_MG   = 6,
    parameter int T_MY   = 2,
    parameter int T_AR   = 1,
    parameter int T_SG   = 4,
    parameter int T_SY   = 2,
    parameter int T_WALK = 3
) (
    input  logic                  MCLK,
    input  logic                  RESET_IN,
    tlc_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        S_MG     = 3'd0,
        S_MY     = 3'd1,
        S_AR1    = 3'd2,
        S_SG     = 3'd3,
        S_SY     = 3'd4,
        S_AR2    = 3'd5,
        S_WALK   = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    // Timer value on which each phase ends (duration - 1).
    localparam logic [7:0] MG_LAST   = 8'(T_MG - 1);
    localparam logic [7:0] MY_LAST   = 8'(T_MY - 1);
    localparam logic [7:0] AR_LAST   = 8'(T_AR - 1);
    localparam logic [7:0] SG_LAST   = 8'(T_SG - 1);
    localparam logic [7:0] SY_LAST   = 8'(T_SY - 1);
    localparam logic [7:0] WALK_LAST = 8'(T_WALK - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] dur_last;
    logic       tick_done;
    logic       side_req, side_req_d;
    logic       ped_req;

    always_ff @(posedge MCLK) begin
        if (RESET_IN) begin
            state_q  <= S_AR2;
            timer_q  <= 8'd0;
            side_req <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            side_req <= side_req_d;
        end
    end

`ifdef TLC_PED_WALK_EN
    logic ped_req_d;

    always_ff @(posedge MCLK) begin
        if (RESET_IN) begin
            ped_req <= 1'b0;
        end else begin
            ped_req <= ped_req_d;
        end
    end

    // Clear on entry to WALK takes priority over a button press on the same edge.
    always_comb begin
        ped_req_d = ped_req;
        if (state_d == S_WALK && state_q != S_WALK) begin
            ped_req_d = 1'b0;
        end else if (bus.PED_BTN) begin
            ped_req_d = 1'b1;
        end
    end
`else
    logic unused_ped_btn;
    assign unused_ped_btn = bus.PED_BTN;
    assign ped_req        = 1'b0;
`endif

    always_comb begin
        dur_last = 8'd0;
        case (state_q)
            S_MG:          dur_last = MG_LAST;
            S_MY:          dur_last = MY_LAST;
            S_AR1, S_AR2:  dur_last = AR_LAST;
            S_SG:          dur_last = SG_LAST;
            S_SY:          dur_last = SY_LAST;
            S_WALK:        dur_last = WALK_LAST;
            default:       dur_last = 8'd0;
        endcase
    end

    assign tick_done = bus.TICK && (timer_q == dur_last);

    // Next-state and lamp decode.
    always_comb begin
        state_d        = state_q;
        bus.MAIN_LIGHT = 3'b100;
        bus.SIDE_LIGHT = 3'b100;
        bus.WALK       = 1'b0;
        bus.STATE      = state_q;

        case (state_q)
            S_MG: begin
                bus.MAIN_LIGHT = 3'b001;
                if (tick_done && (side_req || ped_req)) state_d = S_MY;
            end
            S_MY: begin
                bus.MAIN_LIGHT = 3'b010;
                if (tick_done) state_d = S_AR1;
            end
            S_AR1: begin
`ifdef TLC_PED_WALK_EN
                if (tick_done) state_d = side_req ? S_SG : S_WALK;
`else
                if (tick_done) state_d = S_SG;
`endif
            end
            S_SG: begin
                bus.SIDE_LIGHT = 3'b001;
                if (tick_done) state_d = S_SY;
            end
            S_SY: begin
                bus.SIDE_LIGHT = 3'b010;
                if (tick_done) state_d = S_AR2;
            end
            S_AR2: begin
`ifdef TLC_PED_WALK_EN
                if (tick_done) state_d = ped_req ? S_WALK : S_MG;
`else
                if (tick_done) state_d = S_MG;
`endif
            end
`ifdef TLC_PED_WALK_EN
            S_WALK: begin
                bus.WALK = 1'b1;
                if (tick_done) state_d = S_MG;
            end
`endif
            // Unreachable codes recover through all-red without waiting for a tick.
            default: state_d = S_AR2;
        endcase
    end

    // Timer clears on any state change; otherwise counts ticks. In MG a final
    // tick without a request neither transitions nor counts, so it saturates.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = 8'd0;
        end else if (bus.TICK && !tick_done) begin
            timer_d = timer_q + 8'd1;
        end
    end

    // Clear on entry to SG takes priority over a sensor hit on the same edge.
    always_comb begin
        side_req_d = side_req;
        if (state_d == S_SG && state_q != S_SG) begin
            side_req_d = 1'b0;
        end else if (bus.SIDE_CAR) begin
            side_req_d = 1'b1;
        end
    end

endmodule
